// File: rtl/led_pwm_trail_if.sv
// Pattern load and LED drive bundle between the upstream shifter and the PWM trail block.
interface led_pwm_trail_if;
  logic [7:0] pattern_in;
  logic       pattern_valid;
  logic [3:0] brightness;
  logic       trail_en;
  logic [7:0] led_out;
  logic       frame_start;

  modport master (
    output pattern_in,
    output pattern_valid,
    output brightness,
    output trail_en,
    input  led_out,
    input  frame_start
  );

  modport slave (
    input  pattern_in,
    input  pattern_valid,
    input  brightness,
    input  trail_en,
    output led_out,
    output frame_start
  );
endinterface

// File: rtl/led_pwm_trail.sv
// 8-channel 16-step PWM LED driver with per-LED brightness and optional fade-out trail.
// Pattern load reaches levels 1 cycle after the strobe, led_out 2 cycles after; never stalls input.
module led_pwm_trail #(
  parameter int unsigned PWM_DIV    = 4,
  parameter int unsigned DECAY_DIV  = 12000,
  parameter int unsigned DECAY_STEP = 1
) (
  input  logic         clk,
  input  logic         rst,
  led_pwm_trail_if.slave bus
);

  localparam int unsigned PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int unsigned DW = $clog2(DECAY_DIV);
  localparam logic [PW-1:0] PWM_LAST   = PW'(PWM_DIV - 1);
  localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_DIV - 1);
  localparam logic [3:0]    STEP       = 4'(DECAY_STEP);

  logic [PW-1:0]    pwm_pre;
  logic [3:0]       pwm_cnt;
  logic             pwm_step;
  logic             wrap_q;
  logic [DW-1:0]    decay_pre;
  logic             decay_tick;
  logic [7:0][3:0]  level;
  logic [7:0][3:0]  level_nxt;
  logic [7:0]       led_q;
  logic             frame_q;

  assign pwm_step   = (pwm_pre == PWM_LAST);
  assign decay_tick = (decay_pre == DECAY_LAST);

  // A load always wins for set bits; clear bits either drop, hold, or keep decaying.
  always_comb begin
    level_nxt = level;
    for (int i = 0; i < 8; i++) begin
      if (bus.pattern_valid && bus.pattern_in[i]) begin
        level_nxt[i] = bus.brightness;
      end else if (bus.pattern_valid && !bus.trail_en) begin
        level_nxt[i] = 4'd0;
      end else if (decay_tick && bus.trail_en) begin
        level_nxt[i] = (level[i] > STEP) ? (level[i] - STEP) : 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pwm_pre   <= '0;
      pwm_cnt   <= 4'd0;
      wrap_q    <= 1'b0;
      frame_q   <= 1'b0;
      decay_pre <= '0;
      level     <= '0;
      led_q     <= 8'h00;
    end else begin
      pwm_pre   <= pwm_step ? '0 : (pwm_pre + PW'(1));
      if (pwm_step) begin
        pwm_cnt <= pwm_cnt + 4'd1;
      end
      // frame_start is delayed one more cycle so it lines up with the led_out frame.
      wrap_q    <= pwm_step && (pwm_cnt == 4'hF);
      frame_q   <= wrap_q;
      decay_pre <= decay_tick ? '0 : (decay_pre + DW'(1));
      level     <= level_nxt;
      for (int i = 0; i < 8; i++) begin
        led_q[i] <= (level[i] > pwm_cnt);
      end
    end
  end

  assign bus.led_out     = led_q;
  assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_led_pwm_trail.sv
// Bench for led_pwm_trail: cycle-count reference model feeds a scoreboard, plus directed duty/latency checks.
module tb_led_pwm_trail;

  localparam int unsigned PWM_DIV    = 1;
  localparam int unsigned DECAY_DIV  = 16;
  localparam int unsigned DECAY_STEP = 1;

  logic clk;
  logic rst;
  led_pwm_trail_if bus ();

  led_pwm_trail #(
    .PWM_DIV   (PWM_DIV),
    .DECAY_DIV (DECAY_DIV),
    .DECAY_STEP(DECAY_STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // Reference model: time is counted in edges since the last reset edge, so the PWM
  // position and decay ticks follow directly from arithmetic on that count.
  int          t;
  int          lvl [8];
  logic [8:0]  exp_q [$];

  initial begin : model
    logic [7:0] e_led;
    logic       e_fs;
    int         pw;
    bit         tick;
    t = 0;
    for (int i = 0; i < 8; i++) lvl[i] = 0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        t = 0;
        for (int i = 0; i < 8; i++) lvl[i] = 0;
        e_led = 8'h00;
        e_fs  = 1'b0;
      end else begin
        t++;
        pw = ((t - 1) / PWM_DIV) % 16;
        for (int i = 0; i < 8; i++) e_led[i] = (lvl[i] > pw);
        e_fs = (t >= 2) && (((t - 1) % (16 * PWM_DIV)) == 0);
        tick = ((t % DECAY_DIV) == 0);
        for (int i = 0; i < 8; i++) begin
          if (bus.pattern_valid && bus.pattern_in[i])      lvl[i] = int'(bus.brightness);
          else if (bus.pattern_valid && !bus.trail_en)     lvl[i] = 0;
          else if (tick && bus.trail_en)                   lvl[i] = (lvl[i] > DECAY_STEP) ? lvl[i] - DECAY_STEP : 0;
        end
      end
      exp_q.push_back({e_led, e_fs});
    end
  end

  initial begin : scoreboard
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_led_out", bus.led_out, e[8:1]);
        check("sb_frame_start", bus.frame_start, e[0]);
      end
    end
  end

  int         duty [8];
  logic [15:0] trace0;

  task automatic wait_fs();
    bit found;
    found = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.frame_start) begin
        found = 1;
        break;
      end
    end
    if (!found) check("frame_start_timeout", 0, 1);
  endtask

  // Counts high cycles per LED over one PWM frame beginning at frame_start.
  task automatic frame_duty();
    for (int i = 0; i < 8; i++) duty[i] = 0;
    trace0 = 16'h0000;
    wait_fs();
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      for (int i = 0; i < 8; i++) duty[i] += int'(bus.led_out[i]);
      trace0[k] = bus.led_out[0];
    end
  endtask

  // Call just after a rising edge; the strobe is sampled at the next edge.
  task automatic strobe(input logic [7:0] pat, input logic [3:0] br);
    bus.pattern_in    = pat;
    bus.brightness    = br;
    bus.pattern_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.pattern_valid = 1'b0;
  endtask

  initial begin : stim
    int  lat;
    bit  found;
    int  sum;
    rst               = 1'b0;
    bus.pattern_in    = 8'h00;
    bus.pattern_valid = 1'b0;
    bus.brightness    = 4'd0;
    bus.trail_en      = 1'b0;

    // Reset, then distance from release to first frame_start.
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    lat = 0;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.frame_start) begin
        found = 1;
        break;
      end
    end
    check("first_fs_found", 32'(found), 1);
    check("first_fs_latency", lat, 17);

    // Single LED at full brightness: two-edge latency and 15/16 duty.
    @(posedge clk); #1;
    bus.trail_en = 1'b0;
    strobe(8'h80, 4'd15);
    @(negedge clk);
    check("led7_edge1", 32'(bus.led_out[7]), 0);
    @(negedge clk);
    check("led7_edge2", 32'(bus.led_out[7]), 1);
    frame_duty();
    check("duty7_full", duty[7], 15);
    sum = 0;
    for (int i = 0; i < 7; i++) sum += duty[i];
    check("duty_others_off", sum, 0);

    // Brightness 4 on LED 0 replaces the pattern: lit on the first four PWM steps.
    @(posedge clk); #1;
    strobe(8'h01, 4'd4);
    frame_duty();
    check("duty0_b4", duty[0], 4);
    check("trace0_b4", 32'(trace0), 32'h000F);
    check("duty7_cleared", duty[7], 0);

    // Trail mode with back-to-back loads; LED 4 fades one step per frame and bottoms at 0.
    wait_fs();
    @(posedge clk); #1;
    bus.trail_en = 1'b1;
    strobe(8'h10, 4'd15);
    strobe(8'h08, 4'd15);
    for (int k = 0; k < 16; k++) begin
      frame_duty();
      check($sformatf("fade4_f%0d", k), duty[4], (k < 14) ? 14 - k : 0);
      if (k == 0) check("fade3_f0", duty[3], 14);
    end

    // Load coinciding with a decay tick.
    wait_fs();
    @(posedge clk); #1;
    strobe(8'hFC, 4'd9);
    repeat (12) @(posedge clk);
    #1;
    strobe(8'h03, 4'd7);
    frame_duty();
    check("coinc_duty0", duty[0], 7);
    check("coinc_duty1", duty[1], 7);
    check("coinc_duty2", duty[2], 8);
    check("coinc_duty7", duty[7], 8);

    // Random traffic, checked by the scoreboard only.
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      bus.pattern_in    = 8'($urandom);
      bus.brightness    = 4'($urandom);
      bus.pattern_valid = ($urandom_range(0, 2) == 0);
      bus.trail_en      = 1'($urandom);
    end
    @(posedge clk); #1;
    bus.pattern_valid = 1'b0;

    // Reset mid-fade with a load in the reset cycle: nothing survives.
    bus.trail_en = 1'b1;
    wait_fs();
    @(posedge clk); #1;
    strobe(8'hFF, 4'd9);
    rst = 1'b0;
    strobe(8'hFF, 4'd9);
    rst = 1'b1;
    @(negedge clk);
    check("led_after_reset", bus.led_out, 0);
    frame_duty();
    sum = 0;
    for (int i = 0; i < 8; i++) sum += duty[i];
    check("no_glow_after_reset", sum, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pwm_trail.md
LED_PWM_TRAIL -- requirements
Module: led_pwm_trail

Interface
REQ-001 The block SHALL have parameter PWM_DIV, default 4: clocks per PWM counter step; legal range 1..65535.
REQ-002 The block SHALL have parameter DECAY_DIV, default 12000: clocks per decay tick (1 ms at 12 MHz); legal range 2..2^24-1.
REQ-003 The block SHALL have parameter DECAY_STEP, default 1: level decrement per decay tick; legal range 1..15.
REQ-004 clk  input  1: system clock, 12 MHz.
REQ-005 rst  input  1: reset, synchronous, active-low.
REQ-006 pattern_in  input  8: LED pattern from the upstream shifter; bit i drives LED i.
REQ-007 pattern_valid  input  1: one-cycle strobe; pattern_in is sampled only when this is high.
REQ-008 brightness  input  4: level loaded into lit LEDs; sampled together with pattern_in.
REQ-009 trail_en  input  1: 1 = unlit LEDs fade out; 0 = unlit LEDs drop to 0 on load.
REQ-010 led_out  output  8: registered PWM drive to the physical LEDs.
REQ-011 frame_start  output  1: registered one-cycle pulse at each PWM frame start.

Function
REQ-012 The block SHALL keep an independent 4-bit level[i] per LED, 0..15.
REQ-013 A PWM prescaler SHALL count 0..PWM_DIV-1; when it reaches PWM_DIV-1 it SHALL wrap to 0 and advance pwm_cnt (4-bit, 0..15, wraps 15->0).
REQ-014 frame_start SHALL be 1 in the cycle after pwm_cnt advances 15->0; otherwise 0.
REQ-015 led_out[i] SHALL be registered as (level[i] > pwm_cnt), from the values held in the previous cycle; duty = level/16, level 0 = always off.
REQ-016 A decay prescaler SHALL count 0..DECAY_DIV-1 and assert an internal decay_tick for one cycle on wrap.
REQ-017 On decay_tick with trail_en=1, every level SHALL decrease by DECAY_STEP, saturating at 0 (no wrap below 0).
REQ-018 On decay_tick with trail_en=0, levels SHALL be unchanged.
REQ-019 On pattern_valid, level[i] SHALL load brightness if pattern_in[i]=1.
REQ-020 On pattern_valid with pattern_in[i]=0: level[i] SHALL be set to 0 if trail_en=0, and SHALL be held if trail_en=1.
REQ-021 Latency: a pattern_valid at edge N SHALL update levels at edge N+1 and led_out at edge N+2 at the earliest.
REQ-022 pattern_valid and decay_tick in the same cycle: set bits SHALL load brightness (load wins); clear bits SHALL follow REQ-017/REQ-020.
REQ-023 brightness=0 with bit set SHALL load 0; a brightness change without pattern_valid SHALL NOT affect existing levels.
REQ-024 A trail_en change SHALL take effect at the next decay_tick or pattern_valid only; levels SHALL never change instantaneously because of it.
REQ-025 Back-to-back pattern_valid on consecutive cycles SHALL each be applied; the block SHALL have no input backpressure.
REQ-026 pwm_cnt and both prescalers SHALL run free and SHALL be unaffected by pattern_valid.

Reset
REQ-027 While rst=0 at a clk edge: all levels, pwm_cnt and both prescalers SHALL be set to 0, led_out=8'h00 and frame_start=0.
REQ-028 Reset SHALL override any pattern_valid or decay_tick in the same cycle.
REQ-029 After release, the first pwm_cnt advance SHALL occur PWM_DIV clocks later; decay timing SHALL restart from 0.
REQ-030 Reset mid-fade SHALL clear every level; no residual glow after release.

Verification (PWM_DIV=1, DECAY_DIV=16, DECAY_STEP=1)
REQ-031 Reset held 4 cycles, released -> led_out=8'h00 and frame_start=0 throughout; first frame_start 17 clocks after release.
REQ-032 pattern_in=8'h80, brightness=15, trail_en=0, one valid strobe -> led_out[7] high 15 of every 16 clocks, other bits always 0; led_out[7] first high 2 edges after the strobe.
REQ-033 brightness=4, pattern_in=8'h01 -> led_out[0] high exactly 4 of 16 clocks per frame, on pwm_cnt 0..3.
REQ-034 trail_en=1, load 8'h10 at 15, then valid with 8'h08 -> level[4] drops by 1 every 16 clocks to 0 and stays 0 (no wrap); level[3]=15.
REQ-035 pattern_valid coincident with decay_tick, pattern_in=8'h03, trail_en=1 -> bits 0,1 = brightness; other nonzero levels decrement by 1.
REQ-036 Reset asserted with all levels at 9 during a fade -> next-cycle levels all 0, led_out=8'h00 after release until a new load.
